// File: rtl/fft_frame_engine_if.sv
// fft_frame_engine_if: sample input stream, twiddle ROM port and bin output stream of the FFT frame engine.
interface fft_frame_engine_if #(
   parameter int LOG2N = 6,
   parameter int DW    = 16,
   parameter int TW    = 16
);
   logic signed [DW-1:0] s_data;
   logic                 s_valid;
   logic                 s_ready;
   logic [LOG2N-2:0]     tw_addr;
   logic signed [TW-1:0] tw_cos;
   logic signed [TW-1:0] tw_sin;
   logic [2*DW-1:0]      m_data;
   logic [LOG2N-1:0]     m_index;
   logic                 m_valid;
   logic                 m_last;
   logic                 m_ready;
   modport master (
      input  s_data, s_valid, tw_cos, tw_sin, m_ready,
      output s_ready, tw_addr, m_data, m_index, m_valid, m_last
   );
   modport slave (
      output s_data, s_valid, tw_cos, tw_sin, m_ready,
      input  s_ready, tw_addr, m_data, m_index, m_valid, m_last
   );
endinterface

// File: rtl/fft_frame_engine.sv
// fft_frame_engine: in-place radix-2 DIT FFT over an N-sample real frame, streaming |X[m]|^2 in natural order.
module fft_frame_engine #(
   parameter int LOG2N = 6,
   parameter int DW    = 16,
   parameter int TW    = 16,
   parameter int SCALE = 1
) (
   input  logic               clk,
   input  logic               rst,
   fft_frame_engine_if.master bus,
   output logic               busy,
   output logic [15:0]        frame_count
);
   localparam int N  = 1 << LOG2N;
   localparam int PW = DW + TW + 1;
   localparam logic signed [DW+1:0] HI = (DW+2)'(2 ** (DW - 1) - 1);
   localparam logic signed [DW+1:0] LO = ~HI;
   typedef enum logic [2:0] {LOAD, BF_ADDR, BF_MUL, BF_WR, OUT_PREP, OUT} state_t;
   state_t                 st_q;
   logic                   s_ready_q, busy_q, m_valid_q, m_last_q, ld;
   logic [2*DW-1:0]        m_data_q, mag_d;
   logic [LOG2N-1:0]       m_index_q, i_q, i_rev, nidx, bx, msk, a_idx, b_idx;
   logic [LOG2N-2:0]       b_q, k;
   logic [3:0]             s_q;
   logic [15:0]            fc_q;
   logic signed [DW-1:0]   re_q [N];
   logic signed [DW-1:0]   im_q [N];
   logic signed [DW+1:0]   tr_q, ti_q, tr_d, ti_d;
   logic signed [PW-1:0]   pr, pi;
   logic signed [2*DW-1:0] mr, mi;
   function automatic logic signed [DW-1:0] fit(input logic signed [DW+1:0] x);
      return SCALE != 0 ? DW'(x >>> 1) : x > HI ? DW'(HI) : x < LO ? DW'(LO) : DW'(x);
   endfunction
   always_comb begin
      i_rev = '0;
      for (int n = 0; n < LOG2N; n++) i_rev[n] = i_q[LOG2N-1-n];
   end
   // msk = half-1: low bits of b select j, the rest is the group, spread by one bit to make room for half
   assign bx    = {1'b0, b_q};
   assign msk   = (LOG2N'(1) << s_q) - LOG2N'(1);
   assign a_idx = ((bx & ~msk) << 1) | (bx & msk);
   assign b_idx = a_idx | (msk + LOG2N'(1));
   assign k     = (LOG2N-1)'((bx & msk) << (4'(LOG2N - 1) - s_q));
   assign pr    = PW'(re_q[b_idx]) * PW'(bus.tw_cos) + PW'(im_q[b_idx]) * PW'(bus.tw_sin);
   assign pi    = PW'(im_q[b_idx]) * PW'(bus.tw_cos) - PW'(re_q[b_idx]) * PW'(bus.tw_sin);
   assign tr_d  = (DW+2)'(pr >>> (TW - 1));
   assign ti_d  = (DW+2)'(pi >>> (TW - 1));
   assign nidx  = st_q == OUT_PREP ? '0 : m_index_q + LOG2N'(1);
   assign mr    = (2*DW)'(re_q[nidx]);
   assign mi    = (2*DW)'(im_q[nidx]);
   assign mag_d = $unsigned(mr * mr) + $unsigned(mi * mi);
   assign ld    = st_q == LOAD && s_ready_q && bus.s_valid;
   always_ff @(posedge clk) begin
      if (ld) begin
         re_q[i_rev] <= bus.s_data;
         im_q[i_rev] <= '0;
      end
      if (st_q == BF_WR) begin
         re_q[a_idx] <= fit((DW+2)'(re_q[a_idx]) + tr_q);
         im_q[a_idx] <= fit((DW+2)'(im_q[a_idx]) + ti_q);
         re_q[b_idx] <= fit((DW+2)'(re_q[a_idx]) - tr_q);
         im_q[b_idx] <= fit((DW+2)'(im_q[a_idx]) - ti_q);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q      <= LOAD;
         s_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= '0;
         m_index_q <= '0;
         fc_q      <= '0;
         i_q       <= '0;
         b_q       <= '0;
         s_q       <= '0;
         tr_q      <= '0;
         ti_q      <= '0;
      end else begin
         case (st_q)
            LOAD: begin
               s_ready_q <= 1'b1;
               if (ld) begin
                  i_q <= i_q + LOG2N'(1);
                  if (&i_q) begin
                     st_q      <= BF_ADDR;
                     s_ready_q <= 1'b0;
                     busy_q    <= 1'b1;
                  end
               end
            end
            BF_ADDR: st_q <= BF_MUL;
            BF_MUL: begin
               tr_q <= tr_d;
               ti_q <= ti_d;
               st_q <= BF_WR;
            end
            BF_WR: begin
               b_q  <= b_q + (LOG2N-1)'(1);
               st_q <= BF_ADDR;
               if (&b_q) begin
                  s_q <= s_q + 4'd1;
                  if (s_q == 4'(LOG2N - 1)) begin
                     s_q  <= '0;
                     st_q <= OUT_PREP;
                  end
               end
            end
            OUT_PREP: begin
               m_data_q  <= mag_d;
               m_index_q <= '0;
               m_valid_q <= 1'b1;
               m_last_q  <= 1'b0;
               st_q      <= OUT;
            end
            OUT: begin
               if (bus.m_ready) begin
                  if (m_last_q) begin
                     m_valid_q <= 1'b0;
                     m_last_q  <= 1'b0;
                     fc_q      <= fc_q + 16'd1;
                     s_ready_q <= 1'b1;
                     busy_q    <= 1'b0;
                     st_q      <= LOAD;
                  end else begin
                     m_index_q <= nidx;
                     m_data_q  <= mag_d;
                     m_last_q  <= &nidx;
                  end
               end
            end
            default: st_q <= LOAD;
         endcase
      end
   end
   assign bus.s_ready = s_ready_q;
   assign bus.tw_addr = k;
   assign bus.m_data  = m_data_q;
   assign bus.m_index = m_index_q;
   assign bus.m_valid = m_valid_q;
   assign bus.m_last  = m_last_q;
   assign busy        = busy_q;
   assign frame_count = fc_q;
endmodule
